// File: rtl/tick_div_pkg.sv
// ----------------------------------------------------------------------------
// tick_div_pkg
// Shared constants, types and helpers for the multi-channel tick divider.
//   CNT_W_DEFAULT   : default counter/divisor width
//   DIV_RST_DEFAULT : default reset divisor (1 Hz from a 50 MHz clock)
//   CH_W_MAX        : channel-index width for the largest supported build (8 ch)
//   div_t           : divisor/counter word at the default width
//   slot_t          : pending config slot {valid, ch, div} at default widths
//   ch_width()      : $clog2 of the channel count, never less than 1
// ----------------------------------------------------------------------------
package tick_div_pkg;

    localparam int CNT_W_DEFAULT   = 26;
    localparam int DIV_RST_DEFAULT = 50_000_000;
    localparam int CH_W_MAX        = 3;

    typedef logic [CNT_W_DEFAULT-1:0] div_t;

    typedef struct packed {
        logic                valid;
        logic [CH_W_MAX-1:0] ch;
        div_t                div;
    } slot_t;

    function automatic int ch_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/tick_divider_multi_if.sv
// ----------------------------------------------------------------------------
// tick_divider_multi_if
// Valid/ready configuration port of tick_divider_multi.
//   cfg_valid : request from the host
//   cfg_ready : divider can take a request (pending slot empty)
//   cfg_ch    : target channel index
//   cfg_div   : new divisor for that channel
// Modports: master (host side), slave (divider side).
// ----------------------------------------------------------------------------
interface tick_divider_multi_if
    import tick_div_pkg::*;
#(
    parameter int NUM_CH = 2,
    parameter int CNT_W  = CNT_W_DEFAULT
);
    localparam int CH_W = ch_width(NUM_CH);

    logic             cfg_valid;
    logic             cfg_ready;
    logic [CH_W-1:0]  cfg_ch;
    logic [CNT_W-1:0] cfg_div;

    modport master (
        output cfg_valid,
        output cfg_ch,
        output cfg_div,
        input  cfg_ready
    );

    modport slave (
        input  cfg_valid,
        input  cfg_ch,
        input  cfg_div,
        output cfg_ready
    );

endinterface

// File: rtl/tick_div_ch.sv
// ----------------------------------------------------------------------------
// tick_div_ch
// One divider channel: counter, active divisor, one-cycle tick and 50% square.
//   clk, rst     : clock, asynchronous active-high reset
//   i_en         : run enable; low clears the channel to phase 0
//   i_sync       : phase restart (only when TICK_DIV_SYNC_EN is defined)
//   i_load       : replace the divisor on this edge
//   i_load_div   : divisor to load (already non-zero)
//   o_boundary   : this edge is a period boundary (wrap, disable or restart)
//   o_tick, o_sq : registered outputs
// Optional feature macro: TICK_DIV_SYNC_EN.
// ----------------------------------------------------------------------------
module tick_div_ch
    import tick_div_pkg::*;
#(
    parameter int CNT_W   = CNT_W_DEFAULT,
    parameter int DIV_RST = DIV_RST_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_en,
`ifdef TICK_DIV_SYNC_EN
    input  logic             i_sync,
`endif
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_div,
    output logic             o_boundary,
    output logic             o_tick,
    output logic             o_sq
);

    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_div;
    logic             r_tick;
    logic             r_sq;
    logic             w_wrap;
    logic             w_restart;

    assign w_wrap = (r_cnt == r_div - ONE);

`ifdef TICK_DIV_SYNC_EN
    assign w_restart = !i_en || i_sync;
`else
    assign w_restart = !i_en;
`endif

    // A disabled or restarting channel counts as being at a boundary, so a
    // pending divisor lands on the very next edge instead of waiting.
    assign o_boundary = w_restart || w_wrap;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt  <= '0;
            r_div  <= CNT_W'(DIV_RST);
            r_tick <= 1'b0;
            r_sq   <= 1'b0;
        end else begin
            if (w_restart) begin
                r_cnt  <= '0;
                r_tick <= 1'b0;
                r_sq   <= 1'b0;
            end else if (w_wrap) begin
                r_cnt  <= '0;
                r_tick <= 1'b1;
                r_sq   <= ~r_sq;
            end else begin
                r_cnt  <= r_cnt + ONE;
                r_tick <= 1'b0;
            end
            // The wrap compare above used the old divisor, so the period in
            // flight always completes before the new value takes effect.
            if (i_load) begin
                r_div <= i_load_div;
            end
        end
    end

    assign o_tick = r_tick;
    assign o_sq   = r_sq;

endmodule

// File: rtl/tick_divider_multi.sv
// ----------------------------------------------------------------------------
// tick_divider_multi
// NUM_CH independent clock dividers producing slow enables (tick) and 50%
// square waves (sq), reprogrammable at runtime through a single-entry
// valid/ready config slot; updates land at the target channel's period edge.
//   clk, rst : clock, asynchronous active-high reset
//   ch_en    : per-channel run enable
//   sync_in  : restart all enabled channels at phase 0 (TICK_DIV_SYNC_EN only)
//   cfg      : config port (tick_divider_multi_if.slave)
//   tick     : per-channel one-cycle pulse, registered
//   sq       : per-channel square wave, registered
// Optional feature macro: TICK_DIV_SYNC_EN.
// ----------------------------------------------------------------------------
module tick_divider_multi
    import tick_div_pkg::*;
#(
    parameter int NUM_CH  = 2,
    parameter int CNT_W   = CNT_W_DEFAULT,
    parameter int DIV_RST = DIV_RST_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_CH-1:0]    ch_en,
`ifdef TICK_DIV_SYNC_EN
    input  logic                 sync_in,
`endif
    tick_divider_multi_if.slave  cfg,
    output logic [NUM_CH-1:0]    tick,
    output logic [NUM_CH-1:0]    sq
);

    localparam int CH_W = ch_width(NUM_CH);

    typedef struct packed {
        logic             valid;
        logic [CH_W-1:0]  ch;
        logic [CNT_W-1:0] div;
    } pend_t;

    pend_t              r_pend;
    logic [NUM_CH-1:0]  w_boundary;
    logic [NUM_CH-1:0]  w_load;
    logic               w_apply;
    logic               w_accept;
    logic               w_ch_ok;
    logic [CNT_W-1:0]   w_div_coerced;

    assign cfg.cfg_ready = !r_pend.valid;
    assign w_accept      = cfg.cfg_valid && !r_pend.valid;
    // Out-of-range channel indices (only possible for non power-of-two
    // NUM_CH) complete the handshake but never occupy the slot.
    assign w_ch_ok       = (int'(cfg.cfg_ch) < NUM_CH);
    assign w_div_coerced = (cfg.cfg_div == '0) ? CNT_W'(1) : cfg.cfg_div;

    always_comb begin
        w_load = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            w_load[i] = r_pend.valid && (int'(r_pend.ch) == int'(i)) && w_boundary[i];
        end
    end

    assign w_apply = |w_load;

    // Accept and apply are mutually exclusive: accepting needs an empty slot,
    // applying needs a full one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pend <= '0;
        end else if (w_apply) begin
            r_pend.valid <= 1'b0;
        end else if (w_accept && w_ch_ok) begin
            r_pend <= {1'b1, cfg.cfg_ch, w_div_coerced};
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        tick_div_ch #(
            .CNT_W   (CNT_W),
            .DIV_RST (DIV_RST)
        ) u_ch (
            .clk        (clk),
            .rst        (rst),
            .i_en       (ch_en[g]),
`ifdef TICK_DIV_SYNC_EN
            .i_sync     (sync_in),
`endif
            .i_load     (w_load[g]),
            .i_load_div (r_pend.div),
            .o_boundary (w_boundary[g]),
            .o_tick     (tick[g]),
            .o_sq       (sq[g])
        );
    end

endmodule

// File: tb/tb_tick_divider_multi.sv
// ----------------------------------------------------------------------------
// tb_tick_divider_multi
// Self-checking bench for tick_divider_multi (3 channels, 8-bit, DIV_RST=5).
// Each applied cycle pushes its expected {tick, sq, cfg_ready} to a queue;
// the entry is popped and compared 1 time unit after the clock edge.
// The phase-restart sequence is built only when TICK_DIV_SYNC_EN is defined.
// ----------------------------------------------------------------------------
module tb_tick_divider_multi;

    localparam int NCH  = 3;
    localparam int CW   = 8;
    localparam int DRST = 5;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [NCH-1:0] ch_en = '0;
    logic [NCH-1:0] tick;
    logic [NCH-1:0] sq;
`ifdef TICK_DIV_SYNC_EN
    logic           sync_in = 1'b0;
`endif

    tick_divider_multi_if #(.NUM_CH(NCH), .CNT_W(CW)) bus ();

    tick_divider_multi #(
        .NUM_CH  (NCH),
        .CNT_W   (CW),
        .DIV_RST (DRST)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .ch_en   (ch_en),
`ifdef TICK_DIV_SYNC_EN
        .sync_in (sync_in),
`endif
        .cfg     (bus.slave),
        .tick    (tick),
        .sq      (sq)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] en;
        logic       v;
        logic [1:0] ch;
        logic [7:0] div;
        logic [2:0] t;
        logic [2:0] s;
        logic       r;
    } vec_t;

    typedef struct {
        string      tag;
        logic [6:0] exp;
    } sb_t;

    vec_t tbl[$];
    sb_t  sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic add(input logic [2:0] en, input logic v, input logic [1:0] ch,
                       input logic [7:0] div, input logic [2:0] t, input logic [2:0] s,
                       input logic r);
        vec_t e;
        e.en = en; e.v = v; e.ch = ch; e.div = div; e.t = t; e.s = s; e.r = r;
        tbl.push_back(e);
    endtask

    task automatic check_now(input string tag, input logic [6:0] exp);
        logic [6:0] got;
        got = {tick, sq, bus.cfg_ready};
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got tick=%b sq=%b ready=%b, want tick=%b sq=%b ready=%b",
                     tag, got[6:4], got[3:1], got[0], exp[6:4], exp[3:1], exp[0]);
        end
    endtask

    // Drive one cycle of stimulus, queue its expectation, then compare after the edge.
    task automatic cycle(input logic [2:0] en, input logic v, input logic [1:0] ch,
                         input logic [7:0] div, input logic [2:0] t, input logic [2:0] s,
                         input logic r, input string tag);
        sb_t e;
        ch_en         = en;
        bus.cfg_valid = v;
        bus.cfg_ch    = ch;
        bus.cfg_div   = div;
        e.tag = tag;
        e.exp = {t, s, r};
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check_now(e.tag, e.exp);
    endtask

    // Reset pulse placed between clock edges.
    task automatic reset_pulse(input string tag);
        #2;
        rst = 1'b1;
        #1;
        check_now(tag, {3'b000, 3'b000, 1'b1});
        #2;
        rst = 1'b0;
    endtask

    initial begin
        // ch0 at DIV_RST=5, then a mid-period reload to 3.
        for (int i = 0; i < 4; i++) add(3'b001, 0, 0, 0, 3'b000, 3'b000, 1);
        add(3'b001, 0, 0, 0, 3'b001, 3'b001, 1);
        for (int i = 0; i < 4; i++) add(3'b001, 0, 0, 0, 3'b000, 3'b001, 1);
        add(3'b001, 0, 0, 0, 3'b001, 3'b000, 1);
        add(3'b001, 0, 0, 0, 3'b000, 3'b000, 1);
        add(3'b001, 1, 0, 3, 3'b000, 3'b000, 0);
        add(3'b001, 0, 0, 0, 3'b000, 3'b000, 0);
        add(3'b001, 0, 0, 0, 3'b000, 3'b000, 0);
        add(3'b001, 0, 0, 0, 3'b001, 3'b001, 1);
        add(3'b001, 0, 0, 0, 3'b000, 3'b001, 1);
        add(3'b001, 0, 0, 0, 3'b000, 3'b001, 1);
        add(3'b001, 0, 0, 0, 3'b001, 3'b000, 1);
        add(3'b001, 0, 0, 0, 3'b000, 3'b000, 1);
        add(3'b001, 0, 0, 0, 3'b000, 3'b000, 1);
        add(3'b001, 0, 0, 0, 3'b001, 3'b001, 1);

        bus.cfg_valid = 1'b0;
        bus.cfg_ch    = '0;
        bus.cfg_div   = '0;

        #2;
        check_now("reset_state", {3'b000, 3'b000, 1'b1});
        #10;
        rst = 1'b0;

        for (int i = 0; i < tbl.size(); i++) begin
            cycle(tbl[i].en, tbl[i].v, tbl[i].ch, tbl[i].div,
                  tbl[i].t, tbl[i].s, tbl[i].r, $sformatf("tbl[%0d]", i));
        end

        // div=0 on disabled ch1 (coerced to 1), with a second request held behind it.
        cycle(3'b001, 1, 1, 0, 3'b000, 3'b001, 0, "div0_accept");
        cycle(3'b001, 1, 0, 4, 3'b000, 3'b001, 1, "hold_apply_ch1");
        cycle(3'b001, 1, 0, 4, 3'b001, 3'b000, 0, "hold_accept");
        cycle(3'b011, 0, 0, 0, 3'b010, 3'b010, 0, "div1_first");
        cycle(3'b011, 0, 0, 0, 3'b010, 3'b000, 0, "div1_toggle");
        cycle(3'b011, 0, 0, 0, 3'b011, 3'b011, 1, "apply_div4");
        cycle(3'b011, 0, 0, 0, 3'b010, 3'b001, 1, "div4_c1");
        cycle(3'b011, 0, 0, 0, 3'b010, 3'b011, 1, "div4_c2");
        cycle(3'b011, 0, 0, 0, 3'b010, 3'b001, 1, "div4_c3");
        cycle(3'b011, 0, 0, 0, 3'b011, 3'b010, 1, "div4_wrap");
        // Out-of-range channel index: handshake completes, slot stays free.
        cycle(3'b011, 1, 3, 7, 3'b010, 3'b000, 1, "bad_ch");
        cycle(3'b011, 0, 0, 0, 3'b010, 3'b010, 1, "bad_ch_after");
        // Disable ch1, then ch0 dropped on its wrap edge with an update pending.
        cycle(3'b001, 0, 0, 0, 3'b000, 3'b000, 1, "ch1_disable");
        cycle(3'b001, 0, 0, 0, 3'b001, 3'b001, 1, "ch0_wrap");
        cycle(3'b001, 1, 0, 2, 3'b000, 3'b001, 0, "pend_div2");
        cycle(3'b001, 0, 0, 0, 3'b000, 3'b001, 0, "pend_wait1");
        cycle(3'b001, 0, 0, 0, 3'b000, 3'b001, 0, "pend_wait2");
        cycle(3'b000, 0, 0, 0, 3'b000, 3'b000, 1, "disable_on_wrap");
        cycle(3'b001, 0, 0, 0, 3'b000, 3'b000, 1, "reen_c1");
        cycle(3'b001, 0, 0, 0, 3'b001, 3'b001, 1, "div2_wrap1");
        cycle(3'b001, 0, 0, 0, 3'b000, 3'b001, 1, "div2_c1");
        cycle(3'b001, 0, 0, 0, 3'b001, 3'b000, 1, "div2_wrap2");
        // ch2 at count 3 with an update pending, ch1 ticking; then async reset.
        cycle(3'b110, 0, 0, 0, 3'b010, 3'b010, 1, "pre_rst1");
        cycle(3'b110, 1, 2, 7, 3'b010, 3'b000, 0, "pre_rst2");
        cycle(3'b110, 0, 0, 0, 3'b010, 3'b010, 0, "pre_rst3");
        reset_pulse("async_rst");
        for (int i = 1; i <= 4; i++) begin
            cycle(3'b110, 0, 0, 0, 3'b000, 3'b000, 1, $sformatf("post_rst%0d", i));
        end
        cycle(3'b110, 0, 0, 0, 3'b110, 3'b110, 1, "post_rst_div5");

`ifdef TICK_DIV_SYNC_EN
        reset_pulse("sync_rst");
        cycle(3'b000, 1, 0, 4, 3'b000, 3'b000, 0, "sy_cfg0");
        cycle(3'b000, 1, 1, 6, 3'b000, 3'b000, 1, "sy_apply0");
        cycle(3'b000, 1, 1, 6, 3'b000, 3'b000, 0, "sy_cfg1");
        cycle(3'b000, 0, 0, 0, 3'b000, 3'b000, 1, "sy_apply1");
        for (int i = 1; i <= 3; i++) begin
            cycle(3'b011, 0, 0, 0, 3'b000, 3'b000, 1, $sformatf("sy_free%0d", i));
        end
        sync_in = 1'b1;
        cycle(3'b011, 0, 0, 0, 3'b000, 3'b000, 1, "sy_pulse");
        sync_in = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            logic [2:0] et;
            logic [2:0] es;
            et = {1'b0, (k % 6) == 0, (k % 4) == 0};
            es = {1'b0, ((k / 6) % 2) == 1, ((k / 4) % 2) == 1};
            cycle(3'b011, 0, 0, 0, et, es, 1, $sformatf("sy_k%0d", k));
        end
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
